// File: rtl/vga_pkg.sv
// Shared types and character constants for the VGA text path.
package vga_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } char_buf_state_t;

    localparam logic [6:0] CHAR_FILL = 7'h20;
    localparam logic [6:0] CHAR_NL   = 7'h0A;

endpackage

// File: rtl/char_buffer_if.sv
// Read and write bus of the character buffer; text source is master, buffer is slave.
// Optional wr_append is present only when CHAR_BUFFER_CURSOR_EN is defined.
interface char_buffer_if #(
    parameter int COLS   = 16,
    parameter int ROWS   = 16,
    parameter int CODE_W = 7
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    logic [COL_W-1:0]  rd_col;
    logic [ROW_W-1:0]  rd_row;
    logic [CODE_W-1:0] char_code;
    logic              wr_valid;
    logic              wr_ready;
    logic [COL_W-1:0]  wr_col;
    logic [ROW_W-1:0]  wr_row;
    logic [CODE_W-1:0] wr_code;
`ifdef CHAR_BUFFER_CURSOR_EN
    logic              wr_append;
`endif

    modport master (
        output rd_col, rd_row, wr_valid, wr_col, wr_row, wr_code,
`ifdef CHAR_BUFFER_CURSOR_EN
        output wr_append,
`endif
        input  char_code, wr_ready
    );

    modport slave (
        input  rd_col, rd_row, wr_valid, wr_col, wr_row, wr_code,
`ifdef CHAR_BUFFER_CURSOR_EN
        input  wr_append,
`endif
        output char_code, wr_ready
    );

endinterface

// File: rtl/char_buffer_ram.sv
// Simple dual-port character store: one write port, one registered read port.
// A same-address read and write returns the old contents.
module char_buffer_ram #(
    parameter int DEPTH  = 256,
    parameter int AW     = 8,
    parameter int CODE_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [CODE_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [CODE_W-1:0] rdata
);

    logic [CODE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/char_buffer.sv
// COLS x ROWS character buffer with clear sweep, range checks and read masking.
// Define CHAR_BUFFER_CURSOR_EN to add the append cursor (wr_append, cur_col, cur_row).
module char_buffer
    import vga_pkg::*;
#(
    parameter int                COLS      = 16,
    parameter int                ROWS      = 16,
    parameter int                CODE_W    = 7,
    parameter logic [CODE_W-1:0] FILL_CODE = CODE_W'(CHAR_FILL),
    localparam int               COL_W     = $clog2(COLS),
    localparam int               ROW_W     = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst_n,
    char_buffer_if.slave     bus,
    input  logic             clr_req,
    output logic             busy
`ifdef CHAR_BUFFER_CURSOR_EN
    ,
    output logic [COL_W-1:0] cur_col,
    output logic [ROW_W-1:0] cur_row
`endif
);

    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);

    function automatic logic [AW-1:0] cell_addr(input logic [COL_W-1:0] c,
                                                input logic [ROW_W-1:0] r);
        return AW'(32'(r) * COLS + 32'(c));
    endfunction

    char_buf_state_t   state, state_nxt;
    logic [AW-1:0]     sweep_cnt;
    logic              sweep_last;
    logic              wr_fire;
    logic [COL_W-1:0]  tgt_col;
    logic [ROW_W-1:0]  tgt_row;
    logic              tgt_skip;
    logic              tgt_in_range;
    logic              rd_in_range;
    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [AW-1:0]     ram_raddr;
    logic [CODE_W-1:0] ram_wdata;
    logic [CODE_W-1:0] ram_rdata;
    logic              vld_p1;
    logic              fill_p1;

    assign wr_fire    = bus.wr_valid && bus.wr_ready;
    assign sweep_last = (32'(sweep_cnt) == CELLS - 1);

    // Write target: addressed by default, cursor-driven on append
    always_comb begin
        tgt_col  = bus.wr_col;
        tgt_row  = bus.wr_row;
        tgt_skip = 1'b0;
`ifdef CHAR_BUFFER_CURSOR_EN
        if (bus.wr_append) begin
            tgt_col  = cur_col;
            tgt_row  = cur_row;
            tgt_skip = (bus.wr_code == CODE_W'(CHAR_NL));
        end
`endif
    end

    assign tgt_in_range = (32'(tgt_col) < COLS) && (32'(tgt_row) < ROWS);
    assign rd_in_range  = (32'(bus.rd_col) < COLS) && (32'(bus.rd_row) < ROWS);
    assign ram_raddr    = rd_in_range ? cell_addr(bus.rd_col, bus.rd_row) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= CLEAR;
            busy         <= 1'b1;
            bus.wr_ready <= 1'b0;
        end else begin
            state        <= state_nxt;
            busy         <= (state_nxt == CLEAR);
            bus.wr_ready <= (state_nxt == IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (!clr_req && sweep_last) state_nxt = IDLE;
            IDLE:    if (clr_req) state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = cell_addr(tgt_col, tgt_row);
        ram_wdata = bus.wr_code;
        case (state)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = sweep_cnt;
                ram_wdata = FILL_CODE;
            end
            IDLE:    ram_we = wr_fire && tgt_in_range && !tgt_skip;
            default: ram_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sweep_cnt <= '0;
        else if (clr_req || sweep_last)
            sweep_cnt <= '0;
        else if (state == CLEAR)
            sweep_cnt <= sweep_cnt + 1'b1;
    end

`ifdef CHAR_BUFFER_CURSOR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_col <= '0;
            cur_row <= '0;
        end else if (clr_req) begin
            cur_col <= '0;
            cur_row <= '0;
        end else if (wr_fire && bus.wr_append) begin
            if (tgt_skip || (32'(cur_col) == COLS - 1)) begin
                cur_col <= '0;
                cur_row <= (32'(cur_row) == ROWS - 1) ? '0 : cur_row + 1'b1;
            end else begin
                cur_col <= cur_col + 1'b1;
            end
        end
    end
`endif

    char_buffer_ram #(
        .DEPTH  (CELLS),
        .AW     (AW),
        .CODE_W (CODE_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // p1: RAM output register; mask flags travel alongside it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            fill_p1 <= 1'b1;
        end else begin
            vld_p1  <= 1'b1;
            fill_p1 <= !rd_in_range || (state == CLEAR);
        end
    end

    assign bus.char_code = !vld_p1 ? '0 : (fill_p1 ? FILL_CODE : ram_rdata);

endmodule

// File: tb/tb_char_buffer.sv
// Directed bench for char_buffer: a 16x16 instance and a 20x4 instance for range checks.
module tb_char_buffer;

    logic clk;
    logic rst_n;
    logic clr16, clr20;
    logic busy16, busy20;
    int   n_tests;
    int   n_fail;

    char_buffer_if #(.COLS(16), .ROWS(16), .CODE_W(7)) b16 ();
    char_buffer_if #(.COLS(20), .ROWS(4),  .CODE_W(7)) b20 ();

`ifdef CHAR_BUFFER_CURSOR_EN
    logic [3:0] cc16, cr16;
    logic [4:0] cc20;
    logic [1:0] cr20;
`endif

    char_buffer #(.COLS(16), .ROWS(16)) u_dut16 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (b16.slave),
        .clr_req (clr16),
        .busy    (busy16)
`ifdef CHAR_BUFFER_CURSOR_EN
        ,
        .cur_col (cc16),
        .cur_row (cr16)
`endif
    );

    char_buffer #(.COLS(20), .ROWS(4)) u_dut20 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (b20.slave),
        .clr_req (clr20),
        .busy    (busy20)
`ifdef CHAR_BUFFER_CURSOR_EN
        ,
        .cur_col (cc20),
        .cur_row (cr20)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clocks until busy16 drops, bounded
    task automatic wait_idle16(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy16 && n < 1000);
    endtask

    task automatic read16(input logic [3:0] c, input logic [3:0] r);
        b16.rd_col = c;
        b16.rd_row = r;
        tick();
    endtask

    task automatic read20(input logic [4:0] c, input logic [1:0] r);
        b20.rd_col = c;
        b20.rd_row = r;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        tick(); tick();
        n_tests++;
        if (busy16 !== 1'b1 || b16.wr_ready !== 1'b0 || b16.char_code !== 7'h00) begin
            n_fail++;
            $display("FAIL reset16: busy=%b ready=%b code=%h, want 1 0 00", busy16, b16.wr_ready, b16.char_code);
        end
        n_tests++;
        if (busy20 !== 1'b1 || b20.wr_ready !== 1'b0 || b20.char_code !== 7'h00) begin
            n_fail++;
            $display("FAIL reset20: busy=%b ready=%b code=%h, want 1 0 00", busy20, b20.wr_ready, b20.char_code);
        end
`ifdef CHAR_BUFFER_CURSOR_EN
        n_tests++;
        if (cc16 !== 4'd0 || cr16 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_cursor: cur=(%0d,%0d), want (0,0)", cc16, cr16);
        end
`endif
    endtask

    task automatic test_clear_after_reset();
        int n;
        rst_n = 1'b1;
        wait_idle16(n);
        n_tests++;
        if (n != 256 || b16.wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL init_sweep: busy fell after %0d cycles ready=%b, want 256 1", n, b16.wr_ready);
        end
        n_tests++;
        if (busy20 !== 1'b0 || b20.wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL init_sweep20: busy=%b ready=%b, want 0 1", busy20, b20.wr_ready);
        end
        read16(4'd5, 4'd3);
        n_tests++;
        if (b16.char_code !== 7'h20) begin
            n_fail++;
            $display("FAIL read_fill: got %h, want 20", b16.char_code);
        end
    endtask

    task automatic test_write_read();
        b16.wr_col = 4'd2; b16.wr_row = 4'd1; b16.wr_code = 7'h41; b16.wr_valid = 1'b1;
        b16.rd_col = 4'd2; b16.rd_row = 4'd1;
        tick();
        b16.wr_valid = 1'b0;
        n_tests++;
        if (b16.char_code !== 7'h20) begin
            n_fail++;
            $display("FAIL same_cycle_read: got %h, want 20", b16.char_code);
        end
        tick();
        n_tests++;
        if (b16.char_code !== 7'h41) begin
            n_fail++;
            $display("FAIL next_cycle_read: got %h, want 41", b16.char_code);
        end
    endtask

    task automatic test_range();
        b20.wr_valid = 1'b1;
        b20.wr_col = 5'd17; b20.wr_row = 2'd0; b20.wr_code = 7'h4B;
        tick();
        n_tests++;
        if (b20.wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL range_ready: ready=%b, want 1", b20.wr_ready);
        end
        b20.wr_col = 5'd5;  b20.wr_row = 2'd1; b20.wr_code = 7'h52;
        tick();
        b20.wr_col = 5'd22; b20.wr_row = 2'd1; b20.wr_code = 7'h4D;
        tick();
        b20.wr_valid = 1'b0;
        read20(5'd17, 2'd0);
        n_tests++;
        if (b20.char_code !== 7'h4B) begin
            n_fail++;
            $display("FAIL col17: got %h, want 4b", b20.char_code);
        end
        read20(5'd25, 2'd0);
        n_tests++;
        if (b20.char_code !== 7'h20) begin
            n_fail++;
            $display("FAIL read_oor: got %h, want 20", b20.char_code);
        end
        read20(5'd2, 2'd2);
        n_tests++;
        if (b20.char_code !== 7'h20) begin
            n_fail++;
            $display("FAIL write_oor_dropped: cell(2,2)=%h, want 20", b20.char_code);
        end
        read20(5'd5, 2'd1);
        n_tests++;
        if (b20.char_code !== 7'h52) begin
            n_fail++;
            $display("FAIL cell51: got %h, want 52", b20.char_code);
        end
    endtask

    task automatic test_clr_with_write();
        int n;
        int bad_rdy;
        int bad_rd;
        b16.wr_col = 4'd3; b16.wr_row = 4'd1; b16.wr_code = 7'h42; b16.wr_valid = 1'b1;
        b16.rd_col = 4'd3; b16.rd_row = 4'd1;
        clr16 = 1'b1;
        tick();
        clr16 = 1'b0;
        b16.wr_valid = 1'b0;
        n_tests++;
        if (busy16 !== 1'b1 || b16.wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_start: busy=%b ready=%b, want 1 0", busy16, b16.wr_ready);
        end
        n = 0; bad_rdy = 0; bad_rd = 0;
        do begin
            tick();
            n++;
            if (busy16 && b16.wr_ready !== 1'b0) bad_rdy++;
            if (busy16 && b16.char_code !== 7'h20) bad_rd++;
        end while (busy16 && n < 1000);
        n_tests++;
        if (n != 256) begin
            n_fail++;
            $display("FAIL clr_duration: busy %0d cycles, want 256", n);
        end
        n_tests++;
        if (bad_rdy != 0 || bad_rd != 0) begin
            n_fail++;
            $display("FAIL clr_masking: ready_high=%0d unmasked_reads=%0d, want 0 0", bad_rdy, bad_rd);
        end
        tick();
        n_tests++;
        if (b16.char_code !== 7'h20) begin
            n_fail++;
            $display("FAIL clr_erases_write: got %h, want 20", b16.char_code);
        end
    endtask

    task automatic test_clr_restart();
        int n;
        clr16 = 1'b1;
        tick();
        clr16 = 1'b0;
        repeat (100) tick();
        clr16 = 1'b1;
        tick();
        clr16 = 1'b0;
        wait_idle16(n);
        n_tests++;
        if (n != 256) begin
            n_fail++;
            $display("FAIL clr_restart: busy %0d cycles after restart, want 256", n);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        clr16 = 1'b1;
        tick();
        clr16 = 1'b0;
        repeat (10) tick();
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy16 !== 1'b1 || b16.wr_ready !== 1'b0 || b16.char_code !== 7'h00) begin
            n_fail++;
            $display("FAIL reset_mid_sweep: busy=%b ready=%b code=%h, want 1 0 00", busy16, b16.wr_ready, b16.char_code);
        end
        tick();
        rst_n = 1'b1;
        wait_idle16(n);
        n_tests++;
        if (n != 256) begin
            n_fail++;
            $display("FAIL resweep: busy %0d cycles, want 256", n);
        end
    endtask

`ifdef CHAR_BUFFER_CURSOR_EN
    task automatic append16(input logic [6:0] code);
        b16.wr_append = 1'b1;
        b16.wr_valid  = 1'b1;
        b16.wr_code   = code;
        tick();
        b16.wr_valid  = 1'b0;
        b16.wr_append = 1'b0;
    endtask

    task automatic test_cursor_text();
        b16.wr_col = 4'd9; b16.wr_row = 4'd9;
        append16(7'h48);
        append16(7'h49);
        append16(7'h0A);
        append16(7'h58);
        n_tests++;
        if (cc16 !== 4'd1 || cr16 !== 4'd1) begin
            n_fail++;
            $display("FAIL cursor_end: cur=(%0d,%0d), want (1,1)", cc16, cr16);
        end
        read16(4'd0, 4'd0);
        n_tests++;
        if (b16.char_code !== 7'h48) begin
            n_fail++;
            $display("FAIL cell00: got %h, want 48", b16.char_code);
        end
        read16(4'd1, 4'd0);
        n_tests++;
        if (b16.char_code !== 7'h49) begin
            n_fail++;
            $display("FAIL cell10: got %h, want 49", b16.char_code);
        end
        read16(4'd2, 4'd0);
        n_tests++;
        if (b16.char_code !== 7'h20) begin
            n_fail++;
            $display("FAIL newline_no_write: got %h, want 20", b16.char_code);
        end
        read16(4'd0, 4'd1);
        n_tests++;
        if (b16.char_code !== 7'h58) begin
            n_fail++;
            $display("FAIL cell01: got %h, want 58", b16.char_code);
        end
        b16.wr_valid = 1'b1; b16.wr_code = 7'h50;
        tick();
        b16.wr_valid = 1'b0;
        read16(4'd9, 4'd9);
        n_tests++;
        if (b16.char_code !== 7'h50 || cc16 !== 4'd1 || cr16 !== 4'd1) begin
            n_fail++;
            $display("FAIL addressed_write: cell=%h cur=(%0d,%0d), want 50 (1,1)", b16.char_code, cc16, cr16);
        end
    endtask

    task automatic test_cursor_wrap();
        int n;
        clr16 = 1'b1;
        tick();
        clr16 = 1'b0;
        wait_idle16(n);
        n_tests++;
        if (cc16 !== 4'd0 || cr16 !== 4'd0) begin
            n_fail++;
            $display("FAIL clr_cursor: cur=(%0d,%0d), want (0,0)", cc16, cr16);
        end
        for (int i = 0; i < 256; i++) append16(7'h5A);
        n_tests++;
        if (cc16 !== 4'd0 || cr16 !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_cursor: cur=(%0d,%0d), want (0,0)", cc16, cr16);
        end
        read16(4'd15, 4'd15);
        n_tests++;
        if (b16.char_code !== 7'h5A) begin
            n_fail++;
            $display("FAIL last_cell: got %h, want 5a", b16.char_code);
        end
        append16(7'h59);
        read16(4'd0, 4'd0);
        n_tests++;
        if (b16.char_code !== 7'h59 || cc16 !== 4'd1 || cr16 !== 4'd0) begin
            n_fail++;
            $display("FAIL overwrite00: cell=%h cur=(%0d,%0d), want 59 (1,0)", b16.char_code, cc16, cr16);
        end
    endtask

    task automatic test_reset_mid_write();
        int n;
        b16.wr_append = 1'b1; b16.wr_valid = 1'b1; b16.wr_code = 7'h51;
        tick();
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if (cc16 !== 4'd0 || cr16 !== 4'd0 || busy16 !== 1'b1 || b16.wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_write: cur=(%0d,%0d) busy=%b ready=%b, want (0,0) 1 0", cc16, cr16, busy16, b16.wr_ready);
        end
        b16.wr_append = 1'b0; b16.wr_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_idle16(n);
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clr16 = 1'b0; clr20 = 1'b0;
        b16.rd_col = '0; b16.rd_row = '0; b16.wr_valid = 1'b0;
        b16.wr_col = '0; b16.wr_row = '0; b16.wr_code = '0;
        b20.rd_col = '0; b20.rd_row = '0; b20.wr_valid = 1'b0;
        b20.wr_col = '0; b20.wr_row = '0; b20.wr_code = '0;
`ifdef CHAR_BUFFER_CURSOR_EN
        b16.wr_append = 1'b0;
        b20.wr_append = 1'b0;
`endif
        test_reset();
        test_clear_after_reset();
        test_write_read();
        test_range();
        test_clr_with_write();
        test_clr_restart();
`ifdef CHAR_BUFFER_CURSOR_EN
        test_cursor_text();
        test_cursor_wrap();
        test_reset_mid_write();
`endif
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/char_buffer.md
# char_buffer

Writable, parametrised text buffer for the VGA character path. It holds a COLS × ROWS grid of character codes and serves one synchronous read per clock to the glyph/font stage. Text is loaded at run time through a valid/ready write port, replacing fixed string constants. It sits between the game-logic text source and the font ROM lookup, and sweeps itself to a fill code after reset or on request.

## Interface
Parameters:
- COLS, 16, characters per row (≥2)
- ROWS, 16, number of rows (≥2)
- CODE_W, 7, character code width
- FILL_CODE, 7'h20, code written by clear sweep

Ports (COL_W = $clog2(COLS), ROW_W = $clog2(ROWS)):
- clk  in  1  system clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- rd_col  in  COL_W  read column
- rd_row  in  ROW_W  read row
- char_code  out  CODE_W  registered read data
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_col  in  COL_W  write column
- wr_row  in  ROW_W  write row
- wr_code  in  CODE_W  code to store
- clr_req  in  1  one-cycle pulse, start clear sweep
- busy  out  1  clear sweep in progress
- wr_append  in  1  (CHAR_BUFFER_CURSOR_EN only) write at cursor instead of wr_col/wr_row
- cur_col / cur_row  out  COL_W / ROW_W  (CHAR_BUFFER_CURSOR_EN only) cursor position

## Operation
- FSM states: CLEAR, IDLE.
- Reset: state=CLEAR, sweep counter=0, cursor=(0,0).
- CLEAR: writes FILL_CODE to one cell per cycle in row-major order, (0,0) first and (COLS-1,ROWS-1) last, then goes to IDLE. A clr_req during CLEAR restarts the counter at 0.
- IDLE: a handshake writes wr_code to (wr_col, wr_row). clr_req moves the FSM to CLEAR on the next edge. If clr_req and a write handshake coincide, the write is performed first and the sweep then erases it.
- Out-of-range write address (col ≥ COLS or row ≥ ROWS): the write is accepted but dropped.
- Out-of-range read address: returns FILL_CODE.
- While busy=1, reads return FILL_CODE regardless of RAM content.

## Timing
- Reset values: char_code=0, wr_ready=0, busy=1, cur_col=0, cur_row=0.
- wr_ready and busy are registered. wr_ready = (state==IDLE); busy is its inverse.
- Read latency: 1 cycle. Address is sampled at edge N and char_code is valid after edge N.
- Read and write to the same cell in the same cycle: read returns the old value; the new value is visible one cycle later.
- Clear duration: busy high for exactly COLS*ROWS cycles after the edge that samples clr_req. After reset release the sweep also takes COLS*ROWS cycles.
- rst_n asserted mid-sweep or mid-write: immediate return to reset values; the sweep restarts from (0,0) after release.

## Configuration
- CHAR_BUFFER_CURSOR_EN defined: adds the wr_append, cur_col and cur_row ports.
  - A handshake with wr_append=1 writes at the cursor, then advances it by one column.
  - At col COLS-1 the cursor wraps to col 0 of the next row; at the last row it wraps to (0,0).
  - wr_code==CHAR_NL (7'h0A) with wr_append=1 writes nothing and moves the cursor to (0, row+1), wrapping the same way.
  - Writes with wr_append=0 leave the cursor unchanged. A clear resets the cursor to (0,0).
- Not defined: those ports are absent and every write is addressed.

## Structure
- vga_pkg holds:
  - the char_buf_state_t enum {CLEAR, IDLE}
  - CHAR_FILL (7'h20), the default for FILL_CODE
  - CHAR_NL (7'h0A)
- Sub-module char_buffer_ram: simple dual-port synchronous RAM, one write and one registered read, depth COLS*ROWS, address row*COLS+col. No reset on the storage.
- char_buffer contains the FSM, sweep counter, cursor, range checks and read masking.

## Test plan
- Reset, release, wait 256 cycles (16×16) -> busy falls on cycle 256; read (5,3) returns 7'h20.
- Write 'A' (7'h41) to (2,1), read (2,1) in the same cycle and the next cycle -> 7'h20, then 7'h41.
- Write to (3,1) with clr_req in the same cycle -> busy for 256 cycles; read (3,1) afterwards -> 7'h20; wr_ready low throughout.
- Write to col 17 with COLS=20, ROWS=4 -> accepted. Read col 25 -> 7'h20; no other cell changes.
- CURSOR_EN: append "HI", then 7'h0A, then 'X' -> cells (0,0)='H', (1,0)='I', (0,1)='X'; cursor ends at (1,1).
- CURSOR_EN: 256 appends of 'Z' -> cursor wraps to (0,0); the 257th append overwrites (0,0). Assert rst_n mid-sweep -> outputs return to reset values at once.
